oled_text_line_writer: RTL and testbench

- Sequences the ASCII glyph ROM to render one text line on the OLED.
- Holds a NUM_CHARS-entry character buffer that the host writes.
- On start, looks up each character in the 8-byte-per-glyph ROM and streams the glyph column bytes, leftmost column first, to the SPI byte sender over a valid/ready handshake.
- Sits between the host/text logic and the OLED SPI data path; the ROM is instantiated beside it and driven through rom_addr/rom_data.

---
 rtl/oled_text_line_writer_pkg.sv | 25 ++
 rtl/oled_text_line_writer_if.sv | 9 +
 rtl/oled_char_buffer.sv | 34 +++
 rtl/oled_text_line_writer.sv | 140 ++++++++++++++
 tb/tb_oled_text_line_writer.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_text_line_writer_pkg.sv
// Shared constants, FSM encoding and character-mapping helper for the OLED text line writer.
package oled_text_line_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         GLYPH_BYTES   = 8;
    localparam int         COL_W         = 3;
    localparam logic [7:0] SPACE_CHAR    = 8'h20;
    localparam logic [7:0] FALLBACK_CHAR = 8'h7F;

    // Codes with bit7 set have no glyph; they render as the checkerboard at 0x7F.
    function automatic logic [7:0] map_char(input logic [7:0] c);
        if (c[7]) begin
            return FALLBACK_CHAR;
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/oled_text_line_writer_if.sv
// Column-byte stream from the line writer to the OLED SPI byte sender.
interface oled_text_line_writer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/oled_char_buffer.sv
// Host-writable line buffer: one ASCII code per character cell, reset to spaces.
module oled_char_buffer
    import oled_text_line_writer_pkg::*;
#(
    parameter int NUM_CHARS = 16,
    parameter int IDX_W     = $clog2(NUM_CHARS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_char,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_char
);

    logic [7:0] mem_r [NUM_CHARS];
    logic       wr_ok_s;

    assign wr_ok_s = wr_en && ({1'b0, wr_addr} < (IDX_W + 1)'(NUM_CHARS));
    assign rd_char = mem_r[rd_idx];

    // Buffer storage: cleared to spaces on reset, single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                mem_r[i] <= SPACE_CHAR;
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_char;
        end
    end

endmodule

// File: rtl/oled_text_line_writer.sv
// Renders a buffered text line as glyph column bytes, leftmost column first, over a valid/ready stream.
module oled_text_line_writer
    import oled_text_line_writer_pkg::*;
#(
    parameter int NUM_CHARS = 16,
    parameter int IDX_W     = $clog2(NUM_CHARS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_addr,
    input  logic [7:0]                      wr_char,
    input  logic                            start,
    input  logic                            invert,
    output logic [7:0]                      rom_addr,
    input  logic [63:0]                     rom_data,
    oled_text_line_writer_if.master         byte_if,
    output logic                            busy,
    output logic                            done
);

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   char_idx_r;
    logic [COL_W-1:0]   col_idx_r;
    logic [63:0]        glyph_r;
    logic               inv_r;
    logic [7:0]         rd_char_s;
    logic               hs_s;
    logic               last_col_s;
    logic               last_char_s;

    oled_char_buffer #(
        .NUM_CHARS (NUM_CHARS),
        .IDX_W     (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .rd_idx  (char_idx_r),
        .rd_char (rd_char_s)
    );

    assign hs_s        = (state_r == ST_SEND) && byte_if.byte_ready;
    assign last_col_s  = (col_idx_r == COL_W'(GLYPH_BYTES - 1));
    assign last_char_s = (char_idx_r == IDX_W'(NUM_CHARS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start only matters while idle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: state_next_s = ST_SEND;
            ST_SEND: begin
                if (hs_s && last_col_s) begin
                    state_next_s = last_char_s ? ST_DONE : ST_LOAD;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: character/column counters, glyph shift register and invert latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_idx_r <= '0;
            col_idx_r  <= '0;
            glyph_r    <= 64'h0;
            inv_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        char_idx_r <= '0;
                        inv_r      <= invert;
                    end
                end
                ST_LOAD: begin
                    glyph_r   <= rom_data;
                    col_idx_r <= '0;
                end
                ST_SEND: begin
                    if (hs_s) begin
                        glyph_r   <= {glyph_r[55:0], 8'h00};
                        col_idx_r <= col_idx_r + COL_W'(1);
                        if (last_col_s && !last_char_s) begin
                            char_idx_r <= char_idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; the ROM is only addressed during LOAD.
    always_comb begin
        byte_if.byte_valid = 1'b0;
        byte_if.byte_data  = 8'h00;
        busy               = 1'b0;
        done               = 1'b0;
        rom_addr           = 8'h00;
        case (state_r)
            ST_LOAD: begin
                busy     = 1'b1;
                rom_addr = map_char(rd_char_s);
            end
            ST_SEND: begin
                busy               = 1'b1;
                byte_if.byte_valid = 1'b1;
                byte_if.byte_data  = glyph_r[63:56] ^ {8{inv_r}};
            end
            ST_DONE: done = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oled_text_line_writer.sv
// Directed self-checking bench for oled_text_line_writer with a 2-character line and a small glyph ROM model.
module tb_oled_text_line_writer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [0:0]  wr_addr;
    logic [7:0]  wr_char;
    logic        start;
    logic        invert;
    logic [7:0]  rom_addr;
    logic [63:0] rom_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got[$];
    logic [7:0] addrs[$];
    logic [7:0] exp_q[$];
    int first_valid;
    int last_hs;
    int done_cyc;

    localparam logic [63:0] G_SPACE = 64'h0000_0000_0000_0000;
    localparam logic [63:0] G_ZERO  = 64'h003E_4141_413E_0000;
    localparam logic [63:0] G_ONE   = 64'h0000_417F_4000_0000;
    localparam logic [63:0] G_A     = 64'h407C_4A09_4A7C_4000;
    localparam logic [63:0] G_CHK   = 64'hAA55_AA55_AA55_AA55;

    oled_text_line_writer_if bif();

    oled_text_line_writer #(.NUM_CHARS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .start    (start),
        .invert   (invert),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .byte_if  (bif),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (rom_addr)
            8'h20:   rom_data = G_SPACE;
            8'h30:   rom_data = G_ZERO;
            8'h31:   rom_data = G_ONE;
            8'h41:   rom_data = G_A;
            8'h7F:   rom_data = G_CHK;
            default: rom_data = 64'hF0F0_F0F0_0F0F_0F0F;
        endcase
    end

    task automatic expect_glyph(input logic [63:0] g, input bit inv);
        logic [63:0] t;
        for (int k = 0; k < 8; k++) begin
            t = g << (8 * k);
            exp_q.push_back(t[63:56] ^ {8{inv}});
        end
    endtask

    task automatic write_char(input logic [0:0] a, input logic [7:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input bit inv);
        start = 1'b1; invert = inv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one line from the LOAD cycle onward, recording handshaken bytes and LOAD-cycle ROM addresses.
    task automatic capture(input bit rnd, input bit toggle_inv,
                           input int wc0, input logic [0:0] wa0, input logic [7:0] wd0,
                           input int wc1, input logic [0:0] wa1, input logic [7:0] wd1,
                           input int sc, input string tag);
        bit hold;
        bit r;
        logic [7:0] prev;
        got.delete(); addrs.delete();
        first_valid = -1; last_hs = -1; done_cyc = -1; hold = 1'b0; prev = 8'h00;
        for (int c = 1; c <= 300; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_busy: cycle %0d busy=%b required 1", tag, c, busy);
            end
            if (bif.byte_valid !== 1'b1) addrs.push_back(rom_addr);
            else if (first_valid < 0) first_valid = c;
            if (hold) begin
                n_checks++;
                if (bif.byte_valid !== 1'b1 || bif.byte_data !== prev) begin
                    n_fail++;
                    $display("FAIL %s_stable: cycle %0d valid=%b data=%h required 1/%h", tag, c, bif.byte_valid, bif.byte_data, prev);
                end
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bif.byte_ready = r;
            hold = (bif.byte_valid === 1'b1) && !r;
            prev = bif.byte_data;
            if (bif.byte_valid === 1'b1 && r) begin
                got.push_back(bif.byte_data);
                last_hs = c;
            end
            wr_en   = (c == wc0) || (c == wc1);
            wr_addr = (c == wc1) ? wa1 : wa0;
            wr_char = (c == wc1) ? wd1 : wd0;
            start   = (c == sc);
            if (toggle_inv) invert = ~invert;
            @(posedge clk); #1;
        end
        wr_en = 1'b0; start = 1'b0; bif.byte_ready = 1'b1;
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen within 300 cycles", tag);
        end else begin
            n_checks++;
            if (done_cyc !== last_hs + 1) begin
                n_fail++;
                $display("FAIL %s_done_timing: done at cycle %0d required %0d", tag, done_cyc, last_hs + 1);
            end
            n_checks++;
            if (busy !== 1'b0 || bif.byte_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_done_outputs: busy=%b valid=%b required 0/0", tag, busy, bif.byte_valid);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_done_pulse: done=%b busy=%b after one cycle required 0/0", tag, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bif.byte_valid !== 1'b0 || bif.byte_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b rom_addr=%h required 0/00/0/0/00",
                     bif.byte_valid, bif.byte_data, busy, done, rom_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || bif.byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b valid=%b required 0/0", busy, bif.byte_valid);
        end
    endtask

    task automatic test_basic();
        write_char(1'b0, 8'h31);
        write_char(1'b1, 8'h41);
        exp_q.delete();
        expect_glyph(G_ONE, 1'b0);
        expect_glyph(G_A, 1'b0);
        pulse_start(1'b0);
        capture(1'b0, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, -1, "basic");
        n_checks++;
        if (first_valid !== 2) begin
            n_fail++;
            $display("FAIL basic_first_valid: cycle %0d required 2", first_valid);
        end
        n_checks++;
        if (done_cyc !== 19) begin
            n_fail++;
            $display("FAIL basic_done_cycle: cycle %0d required 19", done_cyc);
        end
        n_checks++;
        if (addrs.size() !== 2 || addrs[0] !== 8'h31 || addrs[1] !== 8'h41) begin
            n_fail++;
            $display("FAIL basic_rom_addr: count %0d first %h required 2 entries 31,41", addrs.size(), addrs[0]);
        end
        n_checks++;
        if (got.size() !== 16) begin
            n_fail++;
            $display("FAIL basic_count: %0d bytes required 16", got.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_invert();
        exp_q.delete();
        expect_glyph(G_ONE, 1'b1);
        expect_glyph(G_A, 1'b1);
        pulse_start(1'b1);
        capture(1'b0, 1'b1, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, -1, "invert");
        invert = 1'b0;
        n_checks++;
        if (got.size() !== 16) begin
            n_fail++;
            $display("FAIL invert_count: %0d bytes required 16", got.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL invert_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete();
        expect_glyph(G_ONE, 1'b0);
        expect_glyph(G_A, 1'b0);
        pulse_start(1'b0);
        capture(1'b1, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, -1, "backpressure");
        n_checks++;
        if (got.size() !== 16) begin
            n_fail++;
            $display("FAIL backpressure_count: %0d bytes required 16", got.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL backpressure_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_fallback();
        write_char(1'b0, 8'hC1);
        exp_q.delete();
        expect_glyph(G_CHK, 1'b0);
        expect_glyph(G_A, 1'b0);
        pulse_start(1'b0);
        capture(1'b0, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, -1, "fallback");
        n_checks++;
        if (addrs.size() < 1 || addrs[0] !== 8'h7F) begin
            n_fail++;
            $display("FAIL fallback_rom_addr: got %h required 7f", addrs[0]);
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fallback_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_write_during_busy();
        write_char(1'b0, 8'h31);
        write_char(1'b1, 8'h41);
        exp_q.delete();
        expect_glyph(G_ONE, 1'b0);
        expect_glyph(G_ZERO, 1'b0);
        pulse_start(1'b0);
        // buf[1] rewritten before it is loaded, buf[0] rewritten mid-glyph, stray start during SEND
        capture(1'b0, 1'b0, 3, 1'b1, 8'h30, 5, 1'b0, 8'h41, 4, "wrbusy");
        n_checks++;
        if (got.size() !== 16 || done_cyc !== 19) begin
            n_fail++;
            $display("FAIL wrbusy_length: %0d bytes done at %0d required 16 bytes done at 19", got.size(), done_cyc);
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrbusy_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrbusy_no_restart: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_midline();
        pulse_start(1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (bif.byte_valid !== 1'b1 || bif.byte_data !== 8'h4A) begin
            n_fail++;
            $display("FAIL midrst_fifth_byte: valid=%b data=%h required 1/4a", bif.byte_valid, bif.byte_data);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bif.byte_valid !== 1'b0 || bif.byte_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs: valid=%b data=%h busy=%b done=%b rom_addr=%h required 0/00/0/0/00",
                     bif.byte_valid, bif.byte_data, busy, done, rom_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        expect_glyph(G_SPACE, 1'b0);
        expect_glyph(G_SPACE, 1'b0);
        pulse_start(1'b0);
        capture(1'b0, 1'b0, -1, 1'b0, 8'h00, -1, 1'b0, 8'h00, -1, "midrst");
        n_checks++;
        if (addrs.size() !== 2 || addrs[0] !== 8'h20 || addrs[1] !== 8'h20) begin
            n_fail++;
            $display("FAIL midrst_rom_addr: count %0d first %h required 2 entries 20,20", addrs.size(), addrs[0]);
        end
        n_checks++;
        if (got.size() !== 16) begin
            n_fail++;
            $display("FAIL midrst_count: %0d bytes required 16", got.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midrst_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 1'b0; wr_char = 8'h00;
        start = 1'b0; invert = 1'b0; bif.byte_ready = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_invert();
        test_backpressure();
        test_fallback();
        test_write_during_busy();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
